// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a valid/ready memory bus, with a
// watchdog that ends hung or unmapped transfers with an error response.

module mem_bus_arbiter_port #(
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        sel_busy,
  input  logic        sel_tout,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);
  assign ready = (sel_busy & s_ready) | sel_tout;
  assign err   = sel_tout;
  assign rdata = sel_tout ? ERR_RDATA : s_rdata;
endmodule

module mem_bus_arbiter #(
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        err_flag,
  output logic [31:0] err_addr,
  input  logic        err_clr
);
  localparam int NUM_M = 2;
  localparam int CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;

  state_t  state, state_d;
  logic    owner, owner_d, last, last_d;
  logic [CW-1:0] cnt, cnt_d;

  logic [NUM_M-1:0]       mv;
  logic [NUM_M-1:0][31:0] maddr, mwdata, m_rdata;
  logic [NUM_M-1:0][3:0]  mwstrb;
  logic [NUM_M-1:0]       m_ready, m_err;
  logic                   sel;

  assign mv     = {m1_valid, m0_valid};
  assign maddr  = {m1_addr,  m0_addr};
  assign mwdata = {m1_wdata, m0_wdata};
  assign mwstrb = {m1_wstrb, m0_wstrb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last;
    cnt_d   = cnt;
    case (state)
      IDLE: if (|mv) begin
        state_d = BUSY;
        cnt_d   = '0;
        owner_d = (mv == 2'b11) ? ~last : mv[1];
      end
      BUSY: begin
        // A late s_ready beats the watchdog in the same cycle.
        if (s_ready) begin
          state_d = IDLE;
          last_d  = owner;
          cnt_d   = '0;
        end else if (!mv[owner]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d = TOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      TOUT: begin
        state_d = IDLE;
        last_d  = owner;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outside BUSY the slave mux parks on master 0.
  assign sel     = (state == BUSY) ? owner : 1'b0;
  assign s_valid = (state == BUSY) & mv[owner];
  assign s_addr  = maddr[sel];
  assign s_wdata = mwdata[sel];
  assign s_wstrb = mwstrb[sel];

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    mem_bus_arbiter_port #(.ERR_RDATA(ERR_RDATA)) u_port (
      .sel_busy (state == BUSY && owner == 1'(i)),
      .sel_tout (state == TOUT && owner == 1'(i)),
      .s_ready  (s_ready),
      .s_rdata  (s_rdata),
      .ready    (m_ready[i]),
      .rdata    (m_rdata[i]),
      .err      (m_err[i])
    );
  end

  assign m0_ready = m_ready[0];
  assign m0_rdata = m_rdata[0];
  assign m0_err   = m_err[0];
  assign m1_ready = m_ready[1];
  assign m1_rdata = m_rdata[1];
  assign m1_err   = m_err[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (state == TOUT) begin
      err_flag <= 1'b1;
      err_addr <= maddr[owner];
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, completion, watchdog, reset.

module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m0_ready, m0_err, m1_valid, m1_ready, m1_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, err_flag, err_clr;
  logic [31:0] s_addr, s_wdata, s_rdata, err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #1;
  endtask

  initial begin
    int hi;
    idle_inputs();
    rst_n = 0;
    #3;
    chk("rst_s_valid",  32'(s_valid),  0);
    chk("rst_m0_ready", 32'(m0_ready), 0);
    chk("rst_m1_ready", 32'(m1_ready), 0);
    chk("rst_err_flag", 32'(err_flag), 0);
    chk("rst_err_addr", err_addr,      0);
    step();
    rst_n = 1;

    // m0 read, slave answers one cycle after s_valid
    step();
    m0_valid = 1; m0_addr = 32'h10;
    #1 chk("rd_idle_s_valid", 32'(s_valid), 0);
    step();
    chk("rd_s_valid", 32'(s_valid), 1);
    chk("rd_s_addr",  s_addr, 32'h10);
    chk("rd_wait_ready", 32'(m0_ready), 0);
    step();
    s_ready = 1; s_rdata = 32'h12345678;
    #1;
    chk("rd_m0_ready", 32'(m0_ready), 1);
    chk("rd_m0_rdata", m0_rdata, 32'h12345678);
    chk("rd_m0_err",   32'(m0_err), 0);
    chk("rd_m1_ready", 32'(m1_ready), 0);
    step();
    m0_valid = 0; s_ready = 0;
    #1 chk("rd_done_ready", 32'(m0_ready), 0);

    // Contention from reset: strict m0, m1, m0, m1 alternation
    do_reset();
    m0_valid = 1; m0_addr = 32'h100;
    m1_valid = 1; m1_addr = 32'h200;
    s_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_s_addr",   s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_m0_ready", 32'(m0_ready), (i % 2 == 0) ? 1 : 0);
      chk("rr_m1_ready", 32'(m1_ready), (i % 2 == 0) ? 0 : 1);
      step();
      chk("rr_idle_s_valid", 32'(s_valid), 0);
    end
    idle_inputs();

    // m1 write
    m1_valid = 1; m1_addr = 32'h03000000; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
    step();
    chk("wr_s_valid", 32'(s_valid), 1);
    chk("wr_s_addr",  s_addr,  32'h03000000);
    chk("wr_s_wdata", s_wdata, 32'hA5A5A5A5);
    chk("wr_s_wstrb", 32'(s_wstrb), 32'hF);
    chk("wr_wait",    32'(m1_ready), 0);
    step();
    s_ready = 1;
    #1;
    chk("wr_m1_ready", 32'(m1_ready), 1);
    chk("wr_m1_err",   32'(m1_err), 0);
    chk("wr_m0_ready", 32'(m0_ready), 0);
    step();
    idle_inputs();

    // Unmapped read: watchdog fires after 64 BUSY cycles
    m0_valid = 1; m0_addr = 32'h12340000;
    step();
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      if (s_valid) hi++;
      step();
    end
    chk("to_busy_cycles", 32'(hi), 64);
    chk("to_s_valid",  32'(s_valid), 0);
    chk("to_m0_ready", 32'(m0_ready), 1);
    chk("to_m0_err",   32'(m0_err), 1);
    chk("to_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("to_m1_ready", 32'(m1_ready), 0);
    step();
    m0_valid = 0;
    #1;
    chk("to_m0_ready_end", 32'(m0_ready), 0);
    chk("to_err_flag", 32'(err_flag), 1);
    chk("to_err_addr", err_addr, 32'h12340000);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("clr_err_flag", 32'(err_flag), 0);
    chk("clr_err_addr", err_addr, 32'h12340000);

    // s_ready on the 64th BUSY cycle is a normal completion
    m0_valid = 1; m0_addr = 32'h20;
    step();
    for (int i = 0; i < 63; i++) step();
    chk("late_s_valid", 32'(s_valid), 1);
    s_ready = 1; s_rdata = 32'hCAFEF00D;
    #1;
    chk("late_m0_ready", 32'(m0_ready), 1);
    chk("late_m0_err",   32'(m0_err), 0);
    chk("late_m0_rdata", m0_rdata, 32'hCAFEF00D);
    step();
    idle_inputs();
    #1;
    chk("late_no_tout",  32'(m0_ready), 0);
    step();
    chk("late_err_flag", 32'(err_flag), 0);

    // Async reset mid-transfer; m0 wins the first tie afterwards
    m0_valid = 1; m0_addr = 32'h300;
    m1_valid = 1; m1_addr = 32'h400;
    step();
    chk("ar_owner_m1", s_addr, 32'h400);
    s_ready = 1;
    #1 chk("ar_pre_m1_ready", 32'(m1_ready), 1);
    rst_n = 0;
    #1;
    chk("ar_s_valid",  32'(s_valid), 0);
    chk("ar_m0_ready", 32'(m0_ready), 0);
    chk("ar_m1_ready", 32'(m1_ready), 0);
    chk("ar_m1_err",   32'(m1_err), 0);
    s_ready = 0;
    #2 rst_n = 1;
    step();
    chk("ar_tie_s_valid", 32'(s_valid), 1);
    chk("ar_tie_owner_m0", s_addr, 32'h300);
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one valid/ready memory bus (32-bit addr/wdata/rdata, 4-bit wstrb) between two masters, e.g. the core and a DMA engine.
- Sits between the masters and the address-decoded slave fabric (rom/ram/gpio); the fabric raises mem_ready only for mapped addresses.
- Arbitrates round-robin and holds the grant until the transfer completes.
- A watchdog terminates transfers to unmapped or hung addresses with an error response, so a master never stalls forever.

Parameters:
TIMEOUT, 64, max cycles a granted transfer may wait for s_ready before forced error completion (>=2)
ERR_RDATA, 32'hDEADBEEF, read data returned on a timed-out transfer

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous reset, active-low
m0_valid  input  1  master 0 request; held with stable addr/wdata/wstrb until m0_ready
m0_ready  output  1  master 0 transfer complete (1-cycle pulse)
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_wstrb  input  4  master 0 byte strobes; 0 = read
m0_rdata  output  32  master 0 read data, valid when m0_ready
m0_err  output  1  master 0 error, high only with m0_ready on timeout
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_err  as m0_*, for master 1
s_valid  output  1  request to slave fabric
s_ready  input  1  slave fabric completion
s_addr  output  32  muxed address
s_wdata  output  32  muxed write data
s_wstrb  output  4  muxed strobes
s_rdata  input  32  slave read data
err_flag  output  1  sticky: any timeout since reset or err_clr
err_addr  output  32  address of most recent timed-out transfer
err_clr  input  1  synchronous clear of err_flag (err_addr kept)

Behaviour:
- Reset: all outputs 0. State=IDLE, owner=0, last_served=1 (m0 wins first tie), counter=0.
- States: IDLE, BUSY, TOUT.
- IDLE:
  - Exactly one mN_valid: owner<=N, go BUSY.
  - Both valid: owner<=!last_served, go BUSY.
  - Neither valid: stay IDLE.
  - s_valid=0 and all mN_ready=0 in IDLE. One cycle arbitration latency.
- BUSY:
  - s_valid = owner's mN_valid.
  - s_addr/s_wdata/s_wstrb = owner's signals; in IDLE/TOUT they show m0's signals, value irrelevant.
  - m_owner_ready = s_ready, combinational. Non-owner ready is 0.
  - s_ready=1: complete; last_served<=owner; counter<=0; go IDLE.
  - Owner valid drops before completion (abort): go IDLE, no ready, last_served unchanged.
  - counter increments each BUSY cycle without s_ready. If counter==TIMEOUT-1 and s_ready=0: go TOUT, s_valid drops next cycle.
  - A late s_ready arriving in the same cycle as the timeout decision wins; it is a normal completion.
- TOUT, one cycle:
  - owner mN_ready=1, mN_err=1, mN_rdata=ERR_RDATA; s_valid=0.
  - err_flag<=1; err_addr<=owner addr; last_served<=owner; go IDLE.
- rdata: both mN_rdata = s_rdata except the owner in TOUT. Consumers qualify rdata with ready.
- err_clr and a timeout in the same cycle: set wins.
- Result: back-to-back transfers from one master take ≥2 cycles each. Under contention the masters alternate strictly.
- Async reset mid-transfer: immediate return to IDLE, s_valid=0, no ready pulse to any master.

Test Plan:
- m0 read 0x00000010, slave ready 1 cycle after s_valid, s_rdata=0x12345678 -> s_valid rises cycle after m0_valid; m0_ready pulses 1 cycle with m0_rdata=0x12345678, m0_err=0; m1_ready stays 0.
- m0 and m1 both valid from reset, continuous requests, immediate s_ready -> grants go m0, m1, m0, m1; s_addr tracks the owner; each master completes exactly once per pair.
- m1 write 0x03000000, wdata=0xA5A5A5A5, wstrb=4'hF, gpio-style ready after 1 cycle -> s_wdata/s_wstrb match; m1_ready for 1 cycle; no err.
- m0 read unmapped 0x12340000, s_ready never asserts, TIMEOUT=64 -> s_valid high 64 cycles, then m0_ready=1, m0_err=1, m0_rdata=0xDEADBEEF for 1 cycle; err_flag=1; err_addr=0x12340000; err_clr then clears err_flag, err_addr unchanged.
- s_ready asserted exactly on the 64th BUSY cycle -> normal completion, err=0, err_flag unchanged.
- rst_n pulsed low mid-transfer -> s_valid and all ready/err drop immediately; after release m0 wins a tie first.
